// File: rtl/trigger_ctrl.sv
// Logic-analyzer capture controller feeding write_mem; optional edge-qualified trigger via `EDGE_TRIGGER_EN.
// Latency: probe is registered onto data in one cycle; state/write_enable update on each edge.
// Backpressure: none, one sample per clock; write_mem has no stall path.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

module trigger_ctrl #(
    parameter int DATA_WIDTH     = `DATA_WIDTH,
    parameter int ADDR_WIDTH     = `ADDR_WIDTH,
    parameter int REQUIRE_PRIMED = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] probe,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [DATA_WIDTH-1:0] trig_mask,
`ifdef EDGE_TRIGGER_EN
    input  logic [DATA_WIDTH-1:0] trig_edge,
`endif
    input  logic [ADDR_WIDTH-1:0] post_count,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  primed,
    output logic                  buf_clear,
    output logic                  write_enable,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  armed,
    output logic                  triggered,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trigger_addr
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic                  we_nxt;
    logic                  trig_nxt;
    logic                  trig_hit;
    logic                  level_ok;
    logic                  edge_ok;
    logic                  fire;

    assign level_ok = (((probe ^ trig_value) & trig_mask) == '0);

`ifdef EDGE_TRIGGER_EN
    logic                  first_armed;
    logic [DATA_WIDTH-1:0] edge_bits;

    // data still holds the previous sample, so probe^data marks a transition this cycle
    assign edge_bits = trig_edge & trig_mask;
    assign edge_ok   = ((edge_bits & ~(probe ^ data)) == '0) && (!first_armed || (edge_bits == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_armed <= 1'b0;
        end else begin
            first_armed <= (state == CLEAR);
        end
    end
`else
    assign edge_ok = 1'b1;
`endif

    assign fire = level_ok && edge_ok && ((REQUIRE_PRIMED == 0) || primed);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        we_nxt    = 1'b0;
        trig_nxt  = triggered;
        trig_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                state_nxt = ARMED;
            end
            ARMED: begin
                we_nxt = 1'b1;
                if (fire) begin
                    state_nxt = POST;
                    cnt_nxt   = post_count;
                    trig_nxt  = 1'b1;
                    trig_hit  = 1'b1;
                end
            end
            POST: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    we_nxt  = 1'b1;
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE: begin
                if (arm) begin
                    state_nxt = CLEAR;
                    trig_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // abort overrides arm and trigger decided above
        if (abort) begin
            state_nxt = IDLE;
            cnt_nxt   = cnt;
            we_nxt    = 1'b0;
            trig_nxt  = 1'b0;
            trig_hit  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            write_enable <= 1'b0;
            data         <= '0;
            triggered    <= 1'b0;
            trigger_addr <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            write_enable <= we_nxt;
            data         <= probe;
            triggered    <= trig_nxt;
            // a write in flight this edge advances waddr before the trigger sample lands
            if (trig_hit) begin
                trigger_addr <= waddr + ADDR_WIDTH'(write_enable);
            end
        end
    end

    assign buf_clear = (state == CLEAR);
    assign armed     = (state == ARMED);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_trigger_ctrl.sv
// Directed bench for trigger_ctrl with a behavioural write_mem model per instance.
module tb_trigger_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       arm0, arm1, abort0, abort1;
    logic [7:0] probe, trig_value, trig_mask;
    logic [3:0] post_count;
`ifdef EDGE_TRIGGER_EN
    logic [7:0] trig_edge;
`endif

    logic       bc0, we0, ar0, tr0, dn0, pr0;
    logic [7:0] d0;
    logic [3:0] ta0, wa0;
    logic [7:0] mem0 [16];
    logic       bc1, we1, ar1, tr1, dn1, pr1;
    logic [7:0] d1;
    logic [3:0] ta1, wa1;
    logic [7:0] mem1 [16];

    int tests = 0;
    int fails = 0;
    int wecnt;

    always #5 clk = ~clk;

    trigger_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .REQUIRE_PRIMED(0)) u_dut (
        .clk(clk), .reset(rst), .arm(arm0), .abort(abort0), .probe(probe),
        .trig_value(trig_value), .trig_mask(trig_mask),
`ifdef EDGE_TRIGGER_EN
        .trig_edge(trig_edge),
`endif
        .post_count(post_count), .waddr(wa0), .primed(pr0),
        .buf_clear(bc0), .write_enable(we0), .data(d0), .armed(ar0),
        .triggered(tr0), .done(dn0), .trigger_addr(ta0)
    );

    trigger_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .REQUIRE_PRIMED(1)) u_dutp (
        .clk(clk), .reset(rst), .arm(arm1), .abort(abort1), .probe(probe),
        .trig_value(trig_value), .trig_mask(trig_mask),
`ifdef EDGE_TRIGGER_EN
        .trig_edge(trig_edge),
`endif
        .post_count(post_count), .waddr(wa1), .primed(pr1),
        .buf_clear(bc1), .write_enable(we1), .data(d1), .armed(ar1),
        .triggered(tr1), .done(dn1), .trigger_addr(ta1)
    );

    // write_mem models: synchronous clear, primed after a full lap of 16 writes
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wa0 <= '0;
            pr0 <= 1'b0;
        end else if (bc0) begin
            wa0 <= '0;
            pr0 <= 1'b0;
        end else if (we0) begin
            mem0[wa0] <= d0;
            wa0       <= wa0 + 4'd1;
            if (wa0 == 4'hF) pr0 <= 1'b1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wa1 <= '0;
            pr1 <= 1'b0;
        end else if (bc1) begin
            wa1 <= '0;
            pr1 <= 1'b0;
        end else if (we1) begin
            mem1[wa1] <= d1;
            wa1       <= wa1 + 4'd1;
            if (wa1 == 4'hF) pr1 <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; arm0 = 0; arm1 = 0; abort0 = 0; abort1 = 0;
        probe = 0; trig_value = 0; trig_mask = 0; post_count = 0;
`ifdef EDGE_TRIGGER_EN
        trig_edge = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", we0, 0);
        check("rst_bc", bc0, 0);
        check("rst_trig", tr0, 0);
        check("rst_done", dn0, 0);
        check("rst_armed", ar0, 0);
        check("rst_taddr", ta0, 0);
        check("rst_data", d0, 0);
        rst = 1'b0;
        tick();

        // 1: level trigger on 8'h2A, post=3
        trig_value = 8'h2A; trig_mask = 8'hFF; post_count = 4'd3;
        arm0 = 1; probe = 8'h1E;
        tick();
        arm0 = 0;
        check("t1_clear", bc0, 1);
        check("t1_clear_we", we0, 0);
        probe = 8'h1F;
        tick();
        check("t1_armed", ar0, 1);
        check("t1_clear_1cyc", bc0, 0);
        probe = 8'h20;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (tr0) break;
            probe = probe + 8'd1;
        end
        check("t1_trig", tr0, 1);
        check("t1_taddr", ta0, 10);
        check("t1_trig_data", d0, 8'h2A);
        wecnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (dn0) break;
            if (we0) wecnt++;
            probe = probe + 8'd1;
            tick();
        end
        check("t1_we_cycles", wecnt, 4);
        check("t1_done", dn0, 1);
        check("t1_done_we", we0, 0);
        check("t1_trig_hold", tr0, 1);
        check("t1_mem_2a", mem0[10], 8'h2A);
        check("t1_mem_2b", mem0[11], 8'h2B);
        check("t1_mem_2d", mem0[13], 8'h2D);

        // 2: REQUIRE_PRIMED instance, match present before primed
        trig_value = 8'h55; post_count = 4'd1; probe = 8'h00;
        arm1 = 1;
        tick();
        arm1 = 0;
        tick();
        probe = 8'h55;
        repeat (5) tick();
        arm1 = 1;
        tick();
        arm1 = 0;
        check("t2_arm_ignored_bc", bc1, 0);
        check("t2_arm_ignored_armed", ar1, 1);
        repeat (11) tick();
        check("t2_no_trig_unprimed", tr1, 0);
        tick();
        check("t2_trig_primed", tr1, 1);
        check("t2_taddr", ta1, 1);
        for (int i = 0; i < 10 && !dn1; i++) tick();
        check("t2_done", dn1, 1);

        // 3: mask 0, post 0 from DONE
        trig_mask = 8'h00; post_count = 4'd0; probe = 8'h77;
        arm0 = 1;
        tick();
        arm0 = 0;
        check("t3_rearm_clr_trig", tr0, 0);
        check("t3_clear", bc0, 1);
        tick();
        tick();
        check("t3_trig_first", tr0, 1);
        check("t3_taddr", ta0, 0);
        check("t3_we_one", we0, 1);
        check("t3_not_done", dn0, 0);
        tick();
        check("t3_done", dn0, 1);
        check("t3_we_off", we0, 0);
        check("t3_mem0", mem0[0], 8'h77);

        // 4: abort during POST, then re-arm
        post_count = 4'd5;
        arm0 = 1;
        tick();
        arm0 = 0;
        repeat (3) tick();
        abort0 = 1;
        tick();
        abort0 = 0;
        check("t4_abort_we", we0, 0);
        check("t4_abort_trig", tr0, 0);
        check("t4_abort_armed", ar0, 0);
        check("t4_abort_done", dn0, 0);
        post_count = 4'd0;
        arm0 = 1;
        tick();
        arm0 = 0;
        check("t4_rearm_clear", bc0, 1);
        repeat (3) tick();
        check("t4_rearm_done", dn0, 1);
        check("t4_rearm_trig", tr0, 1);

        // 5: asynchronous reset mid-POST
        trig_value = 8'h23; trig_mask = 8'hFF; post_count = 4'd3;
        arm0 = 1; probe = 8'h1E;
        tick();
        arm0 = 0;
        for (int i = 0; i < 5; i++) begin
            probe = 8'h1F + 8'(i);
            tick();
        end
        check("t5_trig", tr0, 1);
        check("t5_taddr", ta0, 3);
        probe = 8'h24;
        tick();
        #3;
        rst = 1'b1;
        #1;
        check("t5_async_we", we0, 0);
        check("t5_async_trig", tr0, 0);
        check("t5_async_taddr", ta0, 0);
        check("t5_async_data", d0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        trig_mask = 8'h00; post_count = 4'd1; probe = 8'h3C;
        arm0 = 1;
        tick();
        arm0 = 0;
        tick();
        tick();
        check("t5_post_rst_taddr", ta0, 0);
        tick();
        tick();
        check("t5_post_rst_done", dn0, 1);
        check("t5_post_rst_mem1", mem0[1], 8'h3C);

`ifdef EDGE_TRIGGER_EN
        // 6: edge-qualified bit 0
        trig_edge = 8'h01; trig_value = 8'h01; trig_mask = 8'h01; post_count = 4'd0;
        probe = 8'h01;
        arm0 = 1;
        tick();
        arm0 = 0;
        tick();
        repeat (4) tick();
        check("t6_held_no_trig", tr0, 0);
        probe = 8'h00;
        tick();
        check("t6_low_no_trig", tr0, 0);
        probe = 8'h01;
        tick();
        check("t6_rise_trig", tr0, 1);
        trig_edge = 8'h00;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
